clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
- Time-setting controller for the digital clock datapath (seconds, minutes and hours BCD counters).
- Sequences the user through editing hours, then minutes, then seconds, holding shadow BCD values while the user edits.
- On exit, issues a one-cycle load pulse with the shadow values to the counters' set/load inputs.
- Gates counter advance while editing and drives a blink enable for the field being edited.

Parameters:
- BLINK_DIV, 25000000, clk cycles per blink half-period. Must be ≥2. Counter width is derived as clog2(BLINK_DIV).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- mode_btn  input  1  debounced level, active-high; rising edge advances state
- inc_btn  input  1  debounced level; rising edge increments the edited field
- dec_btn  input  1  debounced level; rising edge decrements the edited field
- cur_hour_H  input  2  current hour tens (0-2)
- cur_hour_L  input  4  current hour units
- cur_min_H  input  3  current minute tens
- cur_min_L  input  4  current minute units
- cur_sec_H  input  3  current second tens
- cur_sec_L  input  4  current second units
- set_pulse  output  1  one-cycle load strobe to all counters
- set_hour_H  output  2  shadow hour tens
- set_hour_L  output  4  shadow hour units
- set_min_H  output  3  shadow minute tens
- set_min_L  output  4  shadow minute units
- set_sec_H  output  3  shadow second tens
- set_sec_L  output  4  shadow second units
- run_en  output  1  counter advance enable
- edit_field  output  2  0=none, 1=hour, 2=min, 3=sec
- blink  output  1  display blank/unblank for the edited field

Behaviour:
- Reset (async, immediate):
  - state=RUN, all shadow regs 0 (00:00:00), set_pulse=0, run_en=1, edit_field=0, blink=0, blink counter 0.
  - Edge-detect history regs are cleared to 0, so a button held through reset produces an edge on the first clk after release of rst.
- Edge detect: each button is registered once. event = btn & ~btn_q. Response is registered, one cycle after the sampled edge.
- States: RUN, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT.
- Transitions, all on mode event:
  - RUN→EDIT_HR: shadow <= cur_* in the same cycle (snapshot).
  - EDIT_HR→EDIT_MIN.
  - EDIT_MIN→EDIT_SEC.
  - EDIT_SEC→COMMIT.
  - COMMIT→RUN unconditionally after 1 cycle; a mode event during COMMIT is ignored.
- run_en: 1 in RUN only; 0 in EDIT_* and COMMIT.
- set_pulse: 1 exactly in the COMMIT cycle. set_* outputs show the shadow regs continuously and are stable during COMMIT.
- edit_field: 1/2/3 in EDIT_HR/MIN/SEC; 0 in RUN and COMMIT.
- Field arithmetic is BCD, applied only in EDIT_* and only to the edited field:
  - inc: units+1; units 9→0 with tens+1.
    - Hours: 23→00.
    - Min/sec: 59→00.
  - dec: units 0→9 with tens−1.
    - Hours: 00→23.
    - Min/sec: 00→59.
  - Values stay in legal ranges: hour 00-23, min/sec 00-59.
  - If cur_* presents an illegal snapshot (e.g. hour 27), the first inc or dec forces the field to 00.
- Simultaneous events:
  - inc&dec in the same cycle: no change.
  - mode together with inc/dec: mode wins, inc/dec dropped.
  - inc/dec in RUN or COMMIT: ignored.
- Blink:
  - In EDIT_*, the counter counts to BLINK_DIV−1, then wraps and toggles blink.
  - On entry to any EDIT_* state, and on any applied inc/dec, the counter is cleared and blink is forced to 1 (field visible).
  - In RUN/COMMIT: blink=0, counter held at 0.
- Reset mid-edit: returns to RUN with no set_pulse; counters are not loaded.

Test Plan:
- Reset → run_en=1, set_pulse=0, edit_field=0, blink=0, shadow 00:00:00.
- cur=12:34:56, one mode edge → next cycle edit_field=1, run_en=0, shadow=12:34:56; three more mode edges → set_pulse high exactly 1 cycle with set_*=12:34:56, then RUN, run_en=1.
- EDIT_HR, shadow hour=23: inc edge → 00. dec edge → 23. Hour 09 + inc → 10 (H=1, L=0). EDIT_SEC, 59 + inc → 00; 00 + dec → 59.
- inc and dec rising in the same cycle at min=30 → min stays 30. mode+inc in the same cycle in EDIT_HR → EDIT_MIN, hour unchanged.
- BLINK_DIV=4, in EDIT_MIN:
  - blink=1 on entry, toggles every 4 cycles.
  - inc edge mid-period → blink=1 and the counter restarts.
- rst asserted in EDIT_SEC with shadow modified → immediate RUN, set_pulse never asserted, shadow=00:00:00.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-set controller: snapshots the running time, walks hour/min/sec edits, then strobes a load.
// Button responses land one clk after the sampled rising edge; no backpressure, every event is consumed.
module clock_set_ctrl #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic [1:0] cur_hour_H,
    input  logic [3:0] cur_hour_L,
    input  logic [2:0] cur_min_H,
    input  logic [3:0] cur_min_L,
    input  logic [2:0] cur_sec_H,
    input  logic [3:0] cur_sec_L,
    output logic       set_pulse,
    output logic [1:0] set_hour_H,
    output logic [3:0] set_hour_L,
    output logic [2:0] set_min_H,
    output logic [3:0] set_min_L,
    output logic [2:0] set_sec_H,
    output logic [3:0] set_sec_L,
    output logic       run_en,
    output logic [1:0] edit_field,
    output logic       blink
);
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {RUN, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

    state_t        state_q, state_d;
    logic          mode_q, inc_q, dec_q;
    logic [1:0]    hour_h_q, hour_h_d;
    logic [3:0]    hour_l_q, hour_l_d;
    logic [2:0]    min_h_q, min_h_d;
    logic [3:0]    min_l_q, min_l_d;
    logic [2:0]    sec_h_q, sec_h_d;
    logic [3:0]    sec_l_q, sec_l_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;
    logic          mode_ev, inc_ev, dec_ev, editing, step_vld, edit_next;

    // Out-of-range snapshots collapse to 00 on the first step.
    function automatic logic [5:0] hour_step(input logic [1:0] h, input logic [3:0] l, input logic up);
        logic [5:0] r;
        if (h > 2'd2 || l > 4'd9 || (h == 2'd2 && l > 4'd3)) r = 6'd0;
        else if (up) begin
            if (h == 2'd2 && l == 4'd3) r = 6'd0;
            else if (l == 4'd9)         r = {h + 2'd1, 4'd0};
            else                        r = {h, l + 4'd1};
        end else begin
            if (h == 2'd0 && l == 4'd0) r = {2'd2, 4'd3};
            else if (l == 4'd0)         r = {h - 2'd1, 4'd9};
            else                        r = {h, l - 4'd1};
        end
        return r;
    endfunction

    function automatic logic [6:0] ms_step(input logic [2:0] h, input logic [3:0] l, input logic up);
        logic [6:0] r;
        if (h > 3'd5 || l > 4'd9) r = 7'd0;
        else if (up) begin
            if (h == 3'd5 && l == 4'd9) r = 7'd0;
            else if (l == 4'd9)         r = {h + 3'd1, 4'd0};
            else                        r = {h, l + 4'd1};
        end else begin
            if (h == 3'd0 && l == 4'd0) r = {3'd5, 4'd9};
            else if (l == 4'd0)         r = {h - 3'd1, 4'd9};
            else                        r = {h, l - 4'd1};
        end
        return r;
    endfunction

    assign mode_ev  = mode_btn & ~mode_q;
    assign inc_ev   = inc_btn & ~inc_q;
    assign dec_ev   = dec_btn & ~dec_q;
    assign editing  = (state_q == EDIT_HR) || (state_q == EDIT_MIN) || (state_q == EDIT_SEC);
    assign step_vld = editing & ~mode_ev & (inc_ev ^ dec_ev);

    always_comb begin
        state_d  = state_q;
        hour_h_d = hour_h_q;
        hour_l_d = hour_l_q;
        min_h_d  = min_h_q;
        min_l_d  = min_l_q;
        sec_h_d  = sec_h_q;
        sec_l_d  = sec_l_q;
        case (state_q)
            RUN: if (mode_ev) begin
                state_d  = EDIT_HR;
                hour_h_d = cur_hour_H;
                hour_l_d = cur_hour_L;
                min_h_d  = cur_min_H;
                min_l_d  = cur_min_L;
                sec_h_d  = cur_sec_H;
                sec_l_d  = cur_sec_L;
            end
            EDIT_HR:  if (mode_ev) state_d = EDIT_MIN;
                      else if (step_vld) {hour_h_d, hour_l_d} = hour_step(hour_h_q, hour_l_q, inc_ev);
            EDIT_MIN: if (mode_ev) state_d = EDIT_SEC;
                      else if (step_vld) {min_h_d, min_l_d} = ms_step(min_h_q, min_l_q, inc_ev);
            EDIT_SEC: if (mode_ev) state_d = COMMIT;
                      else if (step_vld) {sec_h_d, sec_l_d} = ms_step(sec_h_q, sec_l_q, inc_ev);
            default:  state_d = RUN;
        endcase

        // Field is shown solid on entry and after every step so the user sees the new value.
        edit_next = (state_d == EDIT_HR) || (state_d == EDIT_MIN) || (state_d == EDIT_SEC);
        cnt_d     = '0;
        blink_d   = 1'b0;
        if (edit_next) begin
            if (state_d != state_q || step_vld) begin
                blink_d = 1'b1;
            end else if (cnt_q == CNT_MAX) begin
                blink_d = ~blink_q;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                blink_d = blink_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            mode_q   <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            hour_h_q <= '0;
            hour_l_q <= '0;
            min_h_q  <= '0;
            min_l_q  <= '0;
            sec_h_q  <= '0;
            sec_l_q  <= '0;
            cnt_q    <= '0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_btn;
            inc_q    <= inc_btn;
            dec_q    <= dec_btn;
            hour_h_q <= hour_h_d;
            hour_l_q <= hour_l_d;
            min_h_q  <= min_h_d;
            min_l_q  <= min_l_d;
            sec_h_q  <= sec_h_d;
            sec_l_q  <= sec_l_d;
            cnt_q    <= cnt_d;
            blink_q  <= blink_d;
        end
    end

    always_comb begin
        case (state_q)
            EDIT_HR:  edit_field = 2'd1;
            EDIT_MIN: edit_field = 2'd2;
            EDIT_SEC: edit_field = 2'd3;
            default:  edit_field = 2'd0;
        endcase
    end

    assign set_pulse  = (state_q == COMMIT);
    assign run_en     = (state_q == RUN);
    assign blink      = blink_q;
    assign set_hour_H = hour_h_q;
    assign set_hour_L = hour_l_q;
    assign set_min_H  = min_h_q;
    assign set_min_L  = min_l_q;
    assign set_sec_H  = sec_h_q;
    assign set_sec_L  = sec_l_q;

endmodule
